// File: rtl/vec_pkg.sv
// Shared definitions for the packed 3-component signed vector datapaths
// (signed_vector_addition and signed_vector_subtraction_pipe).
package vec_pkg;

  localparam int COMP_W = 19;
  localparam int VEC_W  = 3 * COMP_W;

  localparam int X_HI = 3 * COMP_W - 1;
  localparam int X_LO = 2 * COMP_W;
  localparam int Y_HI = 2 * COMP_W - 1;
  localparam int Y_LO = COMP_W;
  localparam int Z_HI = COMP_W - 1;
  localparam int Z_LO = 0;

  localparam logic signed [COMP_W-1:0] COMP_MAX = 19'sd262143;
  localparam logic signed [COMP_W-1:0] COMP_MIN = -19'sd262144;

  typedef struct packed {
    logic signed [COMP_W-1:0] x;
    logic signed [COMP_W-1:0] y;
    logic signed [COMP_W-1:0] z;
  } vec3_t;

endpackage

// File: rtl/signed_comp_sub_sat.sv
// One vector component: full-precision difference in the first stage,
// overflow detection and optional clamping in the second stage.
module signed_comp_sub_sat #(
  parameter int COMP_W   = 19,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_p1,
  input  logic                     ld_p2,
  input  logic signed [COMP_W-1:0] a,
  input  logic signed [COMP_W-1:0] b,
  output logic signed [COMP_W-1:0] res_p2,
  output logic                     ovf_p2
);

  localparam logic signed [COMP_W-1:0] SAT_MAX = {1'b0, {(COMP_W-1){1'b1}}};
  localparam logic signed [COMP_W-1:0] SAT_MIN = {1'b1, {(COMP_W-1){1'b0}}};

  logic signed [COMP_W:0]   d_p1;
  logic                     ovf_c;
  logic signed [COMP_W-1:0] res_c;

  function automatic logic signed [COMP_W-1:0] sat_narrow(input logic signed [COMP_W:0] d);
    if (SATURATE && (d[COMP_W] ^ d[COMP_W-1]))
      return d[COMP_W] ? SAT_MIN : SAT_MAX;
    else
      return d[COMP_W-1:0];
  endfunction

  // Stage 1: one extra bit keeps every difference exact.
  always_ff @(posedge clk) begin
    if (ld_p1) d_p1 <= {a[COMP_W-1], a} - {b[COMP_W-1], b};
  end

  assign ovf_c = d_p1[COMP_W] ^ d_p1[COMP_W-1];
  assign res_c = sat_narrow(d_p1);

  // Stage 2: narrowed result, cleared on reset so a reset output reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (ld_p2) begin
      res_p2 <= res_c;
      ovf_p2 <= ovf_c;
    end
  end

endmodule

// File: rtl/signed_vector_subtraction_pipe.sv
// Two-stage valid/ready streaming subtractor for packed {x,y,z} signed vectors:
// out = in_vector_1 - in_vector_2 per component, with overflow flags.
module signed_vector_subtraction_pipe
  import vec_pkg::*;
#(
  parameter int  COMP_W   = vec_pkg::COMP_W,
  parameter bit  SATURATE = 1'b1,
  localparam int VEC_W    = 3 * COMP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vector_1,
  input  logic [VEC_W-1:0] in_vector_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_vector,
  output logic [2:0]       out_ovf
);

  logic vld_p1, vld_p2;
  logic adv1, adv2;
  logic ld_p1, ld_p2;

  // A stage may take new data when it is empty or its contents move on.
  assign adv2     = !vld_p2 || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;
  assign ld_p1    = in_valid && in_ready;
  assign ld_p2    = vld_p1 && adv2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p1)      vld_p1 <= 1'b1;
      else if (ld_p2) vld_p1 <= 1'b0;
      if (ld_p2)          vld_p2 <= 1'b1;
      else if (out_ready) vld_p2 <= 1'b0;
    end
  end

  assign out_valid = vld_p2;

  // Index 2 is x (MSBs), 0 is z, matching the {x, y, z} packing of out_ovf.
  for (genvar i = 0; i < 3; i++) begin : g_comp
    signed_comp_sub_sat #(
      .COMP_W   (COMP_W),
      .SATURATE (SATURATE)
    ) u_comp (
      .clk    (clk),
      .rst_n  (rst_n),
      .ld_p1  (ld_p1),
      .ld_p2  (ld_p2),
      .a      (in_vector_1[i*COMP_W +: COMP_W]),
      .b      (in_vector_2[i*COMP_W +: COMP_W]),
      .res_p2 (out_vector[i*COMP_W +: COMP_W]),
      .ovf_p2 (out_ovf[i])
    );
  end

endmodule

// File: tb/tb_signed_vector_subtraction_pipe.sv
// Directed bench for signed_vector_subtraction_pipe: a saturating and a
// wrapping instance driven from the same stimulus.
module tb_signed_vector_subtraction_pipe;

  localparam int CW = 19;
  localparam int VW = 3 * CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic [VW-1:0] a, b;
  logic          in_ready_s, in_ready_w;
  logic          out_valid_s, out_valid_w;
  logic [VW-1:0] out_vec_s, out_vec_w;
  logic [2:0]    ovf_s, ovf_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signed_vector_subtraction_pipe #(.COMP_W(CW), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_vector_1(a), .in_vector_2(b), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_vector(out_vec_s), .out_ovf(ovf_s)
  );

  signed_vector_subtraction_pipe #(.COMP_W(CW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_vector_1(a), .in_vector_2(b), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_vector(out_vec_w), .out_ovf(ovf_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] pk(input int x, input int y, input int z);
    return {x[CW-1:0], y[CW-1:0], z[CW-1:0]};
  endfunction

  // Integer reference model: exact difference, then clamp or wrap.
  task automatic model(input logic [VW-1:0] va, input logic [VW-1:0] vb, input bit sat,
                       output logic [VW-1:0] r, output logic [2:0] o);
    for (int i = 0; i < 3; i++) begin
      logic signed [CW-1:0] ac, bc;
      int d;
      ac = va[i*CW +: CW];
      bc = vb[i*CW +: CW];
      d  = int'(ac) - int'(bc);
      o[i] = (d > 262143) || (d < -262144);
      if (d > 262143)       d = sat ? 262143 : d - 524288;
      else if (d < -262144) d = sat ? -262144 : d + 524288;
      r[i*CW +: CW] = d[CW-1:0];
    end
  endtask

  // One isolated transaction with out_ready high: checks latency and single pulse.
  task automatic send_one(input string tag, input logic [VW-1:0] va, input logic [VW-1:0] vb,
                          input logic [VW-1:0] exp_s, input logic [VW-1:0] exp_w,
                          input logic [2:0] exp_o);
    @(negedge clk);
    in_valid = 1'b1; a = va; b = vb;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 64'(out_valid_s), 64'd0);
    @(negedge clk);
    chk({tag, "_valid"},    64'(out_valid_s), 64'd1);
    chk({tag, "_vec_sat"},  64'(out_vec_s),   64'(exp_s));
    chk({tag, "_ovf_sat"},  64'(ovf_s),       64'(exp_o));
    chk({tag, "_vec_wrap"}, 64'(out_vec_w),   64'(exp_w));
    chk({tag, "_ovf_wrap"}, 64'(ovf_w),       64'(exp_o));
    @(negedge clk);
    chk({tag, "_pulse_end"}, 64'(out_valid_s), 64'd0);
  endtask

  logic [VW-1:0] ra[16], rb[16], rexp[16];
  logic [2:0]    rovf[16];
  logic [VW-1:0] v0, v1, v2;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #2;
    chk("rst_out_valid", 64'(out_valid_s), 64'd0);
    chk("rst_out_vector", 64'(out_vec_s), 64'd0);
    chk("rst_out_ovf", 64'(ovf_s), 64'd0);
    chk("rst_in_ready", 64'(in_ready_s), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send_one("basic", pk(5, -3, 0), pk(2, 4, 0), pk(3, -7, 0), pk(3, -7, 0), 3'b000);
    send_one("ovf", pk(262143, -262144, -262144), pk(-1, 1, -262144),
             pk(262143, -262144, 0), pk(-262144, 262143, 0), 3'b110);
    send_one("zero_minus_min", pk(0, 7, -262144), pk(-262144, 7, -262144),
             pk(262143, 0, 0), pk(-262144, 0, 0), 3'b100);
    send_one("all_ones", {VW{1'b1}}, {VW{1'b1}}, '0, '0, 3'b000);

    // 16 back-to-back pairs at full throughput.
    for (int i = 0; i < 16; i++) begin
      ra[i] = VW'({$urandom, $urandom});
      rb[i] = VW'({$urandom, $urandom});
      model(ra[i], rb[i], 1'b1, rexp[i], rovf[i]);
    end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("stream%0d_valid", i - 2), 64'(out_valid_s), 64'd1);
        chk($sformatf("stream%0d_vec", i - 2), 64'(out_vec_s), 64'(rexp[i - 2]));
        chk($sformatf("stream%0d_ovf", i - 2), 64'(ovf_s), 64'(rovf[i - 2]));
      end
      if (i < 16) begin
        chk($sformatf("stream%0d_in_ready", i), 64'(in_ready_s), 64'd1);
        in_valid = 1'b1; a = ra[i]; b = rb[i];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("stream_drained", 64'(out_valid_s), 64'd0);

    // Backpressure: two pairs fill the pipe, the third waits for out_ready.
    out_ready = 1'b0;
    v0 = pk(100, -100, 1); v1 = pk(-5, 6, -7); v2 = pk(1000, 2000, -3000);
    in_valid = 1'b1; a = v0; b = pk(1, 1, 1);
    #1 chk("bp_ready0", 64'(in_ready_s), 64'd1);
    @(negedge clk);
    a = v1; b = pk(0, 0, 0);
    chk("bp_ready1", 64'(in_ready_s), 64'd1);
    @(negedge clk);
    a = v2; b = pk(-1, -1, -1);
    chk("bp_ready2_blocked", 64'(in_ready_s), 64'd0);
    chk("bp_first_valid", 64'(out_valid_s), 64'd1);
    chk("bp_first_vec", 64'(out_vec_s), 64'(pk(99, -101, 0)));
    @(negedge clk);
    chk("bp_hold_ready", 64'(in_ready_s), 64'd0);
    chk("bp_hold_valid", 64'(out_valid_s), 64'd1);
    chk("bp_hold_vec", 64'(out_vec_s), 64'(pk(99, -101, 0)));
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready_s), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_valid", 64'(out_valid_s), 64'd1);
    chk("bp_second_vec", 64'(out_vec_s), 64'(pk(-5, 6, -7)));
    @(negedge clk);
    chk("bp_third_valid", 64'(out_valid_s), 64'd1);
    chk("bp_third_vec", 64'(out_vec_s), 64'(pk(1001, 2001, -2999)));
    @(negedge clk);
    chk("bp_drained", 64'(out_valid_s), 64'd0);

    // Reset with both stages occupied.
    out_ready = 1'b0;
    in_valid = 1'b1; a = pk(0, 0, 0); b = pk(-262144, 0, 0);
    @(negedge clk);
    a = pk(9, 9, 9); b = pk(1, 2, 3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_full_valid", 64'(out_valid_s), 64'd1);
    chk("mid_full_ovf", 64'(ovf_s), 64'b100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid_s), 64'd0);
    chk("mid_rst_vec", 64'(out_vec_s), 64'd0);
    chk("mid_rst_ovf", 64'(ovf_s), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready_s), 64'd1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", i), 64'(out_valid_s), 64'd0);
    end
    send_one("post_rst", pk(10, 20, 30), pk(1, 2, 3), pk(9, 18, 27), pk(9, 18, 27), 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/signed_vector_subtraction_pipe.md
Name: signed_vector_subtraction_pipe

Overview:
- Pipelined streaming subtractor for packed 3-component signed vectors: out = in_vector_1 - in_vector_2, per component.
- Inverse companion to signed_vector_addition. Used for ray-tracing difference vectors, e.g. hit_point - ray_origin and light_pos - hit_point.
- Valid/ready on both sides, full throughput, 2-cycle latency, configurable saturation with per-component overflow flags.

Parameters:
- COMP_W, 19, width of one signed two's-complement component.
- VEC_W, 3*COMP_W (57), packed vector width; derived, do not override.
- SATURATE, 1. 1 = clamp to signed range on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector pair is valid.
- in_ready  out  1  block accepts the pair this cycle.
- in_vector_1  in  VEC_W  minuend {x[56:38], y[37:19], z[18:0]}.
- in_vector_2  in  VEC_W  subtrahend, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_vector  out  VEC_W  difference, same packing.
- out_ovf  out  3  per-component overflow {x, y, z}, aligned with out_vector.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, out_vector=0, out_ovf=0. in_ready is combinational and reads 1 while rst_n is low.
- Transfers happen on a rising edge when valid && ready on that side.
- Stage 1 (S1): on input accept, register each component difference sign-extended to COMP_W+1 bits: d = sext(a) - sext(b). Never drop bits.
- Stage 2 (S2): from d, compute ovf = d[COMP_W] ^ d[COMP_W-1].
  - SATURATE=1 and ovf: result = d[COMP_W] ? -2^(COMP_W-1) : 2^(COMP_W-1)-1.
  - Otherwise: result = d[COMP_W-1:0].
  - Register the result and ovf into out_vector and out_ovf.
- out_ovf reports overflow regardless of SATURATE.
- Advance rules:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1.
  - S1 loads on in_valid && in_ready. S2 loads from S1 when s1_valid && adv2.
  - s1_valid clears when S1 moves to S2 and no new input is accepted.
  - s2_valid clears on output accept when S1 is empty.
- Latency: exactly 2 cycles from input accept to out_valid when out_ready is held high. Throughput 1 vector/cycle.
- Backpressure:
  - While out_ready=0, out_vector, out_ovf and out_valid are held stable.
  - At most 2 vectors in flight. in_ready drops when both stages are valid and out_ready=0.
  - Order is strictly preserved; no loss or duplication.
- Simultaneous output accept and input accept with both stages full: S2 takes S1 and S1 takes the new input in the same edge (no bubble).
- in_vector_* are ignored when in_valid=0; registers do not load, so no power toggle.
- Reset mid-operation: all in-flight data is discarded, out_valid falls immediately (async), and nothing is emitted after release until a new accept.
- Boundaries:
  - (-2^18) - (-2^18) = 0, no ovf.
  - 0 - (-2^18) = 2^18 overflows: saturates to 262143, or wraps to -262144 when SATURATE=0.
  - All-ones minus all-ones = 0.

Decomposition:
- Shared package vec_pkg:
  - COMP_W=19, VEC_W=57.
  - Field slice constants X_HI/X_LO/Y_HI/Y_LO/Z_HI/Z_LO.
  - Constants COMP_MAX=262143, COMP_MIN=-262144.
  - Packed vec3 typedef; signed_vector_addition uses the same package.
- One natural sub-module: signed_comp_sub_sat, one component (subtract, overflow detect, saturate), instantiated 3x. The pipeline control stays in the top.

Test Plan:
- a=(5,-3,0), b=(2,4,0), out_ready=1 -> 2 cycles after accept: out=(3,-7,0), out_ovf=3'b000, single out_valid pulse.
- SATURATE=1, a=(262143,-262144,-262144), b=(-1,1,-262144) -> out=(262143,-262144,0), out_ovf=3'b110.
- SATURATE=0, same vectors -> out=(-262144,262143,0), out_ovf=3'b110.
- a=b={57{1'b1}} -> out=0, out_ovf=0. Then 16 back-to-back random pairs with out_ready=1 -> 16 results matching a golden model, consecutive cycles, in order.
- out_ready=0, three back-to-back pairs -> first two accepted, in_ready=0 on the third until out_ready=1. Outputs held stable and emitted in order, no loss.
- Both stages valid, rst_n pulsed low mid-cycle -> out_valid=0 and out_vector=0 asynchronously. After release: no output until a new input is accepted.
